ondra_printer_capture: RTL and testbench

// Downstream consumer of the core's parallel printer port (Parallel_Data_OUT / NON_STB / BUSY).

---
 rtl/ondra_printer_capture.sv | 171 +++++++++++++++++
 tb/tb_ondra_printer_capture.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ondra_printer_capture.sv
`default_nettype none
// ============================================================================
// Module      : ondra_printer_capture
// Description : Captures bytes strobed out of the Ondra parallel printer port
//               into a FWFT FIFO and drives BUSY back to the core.
// Revision    : 1.0 - initial release
// ============================================================================
module ondra_printer_capture #(
   parameter int DEPTH_LOG2 = 4,
   parameter int BUSY_HOLD  = 16
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic [7:0]            pdata,
   input  logic                  non_stb,
   output logic                  busy,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DEPTH_LOG2:0]   fill,
   output logic                  overflow,
   input  logic                  ovf_clr
);

   localparam int                     c_DEPTH     = 2 ** DEPTH_LOG2;
   localparam int                     c_CNT_W     = (BUSY_HOLD > 1) ? $clog2(BUSY_HOLD) : 1;
   localparam logic [c_CNT_W-1:0]     c_HOLD_LOAD = c_CNT_W'(BUSY_HOLD - 1);
   localparam logic [DEPTH_LOG2:0]    c_FULL      = (DEPTH_LOG2 + 1)'(c_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   logic                  r_stb_s1;
   logic                  r_stb_s2;
   logic                  r_stb_s2_d;
   logic [7:0]            r_pd_s1;
   logic [7:0]            r_pd_s2;
   logic                  r_live;
   logic                  r_armed;
   state_t                r_state;
   logic [7:0]            r_byte;
   logic [c_CNT_W-1:0]    r_cnt;
   logic                  r_busy;
   logic [7:0]            r_mem [c_DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_fill;
   logic                  r_overflow;

   logic                  w_fall;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic [DEPTH_LOG2:0]   w_fill_nx;
   logic                  w_full_nx;

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_stb_s1   <= 1'b1;
         r_stb_s2   <= 1'b1;
         r_stb_s2_d <= 1'b1;
         r_pd_s1    <= 8'h00;
         r_pd_s2    <= 8'h00;
         r_live     <= 1'b0;
         r_armed    <= 1'b0;
      end else begin
         r_stb_s1   <= non_stb;
         r_stb_s2   <= r_stb_s1;
         r_stb_s2_d <= r_stb_s2;
         r_pd_s1    <= pdata;
         r_pd_s2    <= r_pd_s1;
         r_live     <= 1'b1;
         // Only arm once the pin itself has been sampled high after reset, so a
         // strobe already low at reset release is never mistaken for a new fall.
         r_armed    <= r_armed | (r_live & r_stb_s1);
      end
   end

   assign w_fall = r_armed & ~r_stb_s2 & r_stb_s2_d;

   assign w_pop  = (r_fill != '0) & out_ready;
   assign w_push = (r_state == S_CAPTURE) & ((r_fill != c_FULL) | w_pop);
   assign w_drop = (r_state == S_CAPTURE) & ~w_push;

   always_comb begin
      w_fill_nx = r_fill;
      if (w_push & ~w_pop) begin
         w_fill_nx = r_fill + 1'b1;
      end else if (~w_push & w_pop) begin
         w_fill_nx = r_fill - 1'b1;
      end
   end

   assign w_full_nx = (w_fill_nx == c_FULL);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_byte  <= 8'h00;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  r_state <= S_CAPTURE;
                  r_byte  <= r_pd_s2;
                  r_busy  <= 1'b1;
               end else begin
                  r_busy  <= w_full_nx;
               end
            end
            S_CAPTURE: begin
               r_state <= S_HOLD;
               r_cnt   <= c_HOLD_LOAD;
               r_busy  <= 1'b1;
            end
            S_HOLD: begin
               r_busy <= 1'b1;
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (r_stb_s2) begin
                  r_state <= S_IDLE;
                  r_busy  <= w_full_nx;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= w_full_nx;
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < c_DEPTH; i++) begin
            r_mem[i] <= 8'h00;
         end
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_fill     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= r_byte;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_fill <= w_fill_nx;
         if (ovf_clr) begin
            r_overflow <= 1'b0;
         end else if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign busy      = r_busy;
   assign out_data  = r_mem[r_rd_ptr];
   assign out_valid = (r_fill != '0);
   assign fill      = r_fill;
   assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ondra_printer_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_ondra_printer_capture
// Description : Directed plus randomized bench for ondra_printer_capture,
//               checked against a queue-based model of the capture rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ondra_printer_capture;

   localparam int c_DEPTH_LOG2 = 4;
   localparam int c_BUSY_HOLD  = 16;
   localparam int c_DEPTH      = 2 ** c_DEPTH_LOG2;

   logic                  clk_sys = 1'b0;
   logic                  reset;
   logic [7:0]            pdata;
   logic                  non_stb;
   logic                  busy;
   logic [7:0]            out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [c_DEPTH_LOG2:0] fill;
   logic                  overflow;
   logic                  ovf_clr;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] q[$];
   logic       m_ovf = 1'b0;
   logic [7:0] tmp;

   ondra_printer_capture #(
      .DEPTH_LOG2 (c_DEPTH_LOG2),
      .BUSY_HOLD  (c_BUSY_HOLD)
   ) dut (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .pdata     (pdata),
      .non_stb   (non_stb),
      .busy      (busy),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .fill      (fill),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // One strobe of low_len sampled-low edges; edge index k=0 is the first edge
   // that sees non_stb low. Busy must rise at k=2, the byte lands at k=3 and
   // busy falls at max(3+BUSY_HOLD, low_len+2) unless the FIFO ends up full.
   task automatic strobe(input logic [7:0] d, input int low_len,
                         input bit pop_in_cap, input bit clr_in_cap);
      bit full_before;
      int nominal;
      int exp_exit;
      int got_exit;
      full_before = (q.size() == c_DEPTH);
      nominal     = (3 + c_BUSY_HOLD > low_len + 2) ? 3 + c_BUSY_HOLD : low_len + 2;
      got_exit    = -1;
      pdata       = d;
      non_stb     = 1'b0;
      for (int k = 0; k < nominal + 4; k++) begin
         tick();
         if (k == low_len - 1) non_stb = 1'b1;
         if (k == 1) chk("busy_before_capture", busy, full_before);
         if (k == 2) begin
            chk("busy_rise", busy, 1'b1);
            if (pop_in_cap) begin
               if (q.size() != 0) chk("head_before_pop", out_data, q[0]);
               out_ready = 1'b1;
            end
            if (clr_in_cap) ovf_clr = 1'b1;
         end
         if (k == 3) begin
            out_ready = 1'b0;
            ovf_clr   = 1'b0;
            if (pop_in_cap && q.size() != 0) tmp = q.pop_front();
            if (q.size() < c_DEPTH) q.push_back(d);
            else if (!clr_in_cap) m_ovf = 1'b1;
            if (clr_in_cap) m_ovf = 1'b0;
            chk("fill_after_capture", fill, q.size());
            chk("valid_after_capture", out_valid, q.size() != 0);
            chk("overflow_after_capture", overflow, m_ovf);
            if (q.size() != 0) chk("head_after_capture", out_data, q[0]);
         end
         if (k >= 3 && !busy) begin
            got_exit = k;
            break;
         end
      end
      exp_exit = (q.size() == c_DEPTH) ? -1 : nominal;
      chk("busy_fall_edge", got_exit, exp_exit);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) begin
         out_ready = 1'b1;
         chk("drain_valid", out_valid, q.size() != 0);
         if (q.size() != 0) chk("drain_data", out_data, q[0]);
         tick();
         if (q.size() != 0) tmp = q.pop_front();
         chk("drain_fill", fill, q.size());
      end
      out_ready = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      non_stb   = 1'b1;
      pdata     = 8'h00;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
      repeat (3) tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, 8'h00);
      chk("rst_fill", fill, 0);
      chk("rst_overflow", overflow, 1'b0);
      reset = 1'b0;
      repeat (3) tick();

      // Single byte
      strobe(8'h41, 4, 1'b0, 1'b0);
      drain(1);

      // Fill to full, forced drop, clear coincident with a second drop, drain
      for (int i = 0; i < c_DEPTH; i++) strobe(8'(i), 3, 1'b0, 1'b0);
      chk("full_fill", fill, c_DEPTH);
      chk("full_busy", busy, 1'b1);
      strobe(8'hFF, 3, 1'b0, 1'b0);
      chk("ovf_set", overflow, 1'b1);
      chk("ovf_fill", fill, c_DEPTH);
      strobe(8'hEE, 3, 1'b0, 1'b1);
      chk("ovf_cleared", overflow, 1'b0);
      drain(c_DEPTH);
      drain(2);

      // Full with a pop during the capture cycle
      for (int i = 0; i < c_DEPTH; i++) strobe(8'($urandom), 2, 1'b0, 1'b0);
      strobe(8'hAA, 3, 1'b1, 1'b0);
      chk("fullpop_fill", fill, c_DEPTH);
      chk("fullpop_ovf", overflow, 1'b0);
      drain(c_DEPTH);

      // Long strobe is one byte
      strobe(8'h55, 200, 1'b0, 1'b0);
      chk("long_fill", fill, 1);

      // Reset three cycles into HOLD with fill=3
      strobe(8'($urandom), 5, 1'b0, 1'b0);
      pdata   = 8'h99;
      non_stb = 1'b0;
      repeat (7) tick();
      q.push_back(8'h99);
      chk("prereset_fill", fill, q.size());
      reset = 1'b1;
      #1;
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_fill", fill, 0);
      chk("midrst_ovf", overflow, 1'b0);
      q.delete();
      m_ovf = 1'b0;
      tick();
      reset = 1'b0;
      repeat (30) tick();
      chk("held_low_fill", fill, 0);
      chk("held_low_busy", busy, 1'b0);
      non_stb = 1'b1;
      repeat (4) tick();
      strobe(8'h77, 3, 1'b0, 1'b0);
      chk("after_rst_fill", fill, 1);

      // Randomized strobes and partial drains
      for (int i = 0; i < 12; i++) begin
         strobe(8'($urandom), int'($urandom_range(1, 24)), 1'b0, 1'b0);
         if ($urandom_range(0, 2) == 0) drain(int'($urandom_range(0, q.size() + 1)));
      end
      drain(q.size() + 1);
      chk("final_fill", fill, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
